// File: rtl/reset_seq.sv
// Sequenced reset controller: merges external, software and watchdog reset requests, stretches
// each reset event, then releases NUM_OUT reset domains in order and records the cause.

module reset_seq_lane (
    input  logic clk_i,
    input  logic internal_rst_n,
    input  logic clr,
    input  logic set,
    output logic rst_no
);
    always_ff @(posedge clk_i or negedge internal_rst_n) begin
        if (!internal_rst_n) rst_no <= 1'b0;
        else if (clr)        rst_no <= 1'b0;
        else if (set)        rst_no <= 1'b1;
    end
endmodule

module reset_seq #(
    parameter int NUM_OUT        = 3,
    parameter int STRETCH_CYCLES = 8,
    parameter int STEP_CYCLES    = 4,
    parameter int WDT_TIMEOUT    = 1024
) (
    input  logic               clk_i,
    input  logic               internal_rst_n,
    input  logic               ext_rst_ni,
    input  logic               sw_rst_req_i,
    input  logic               wdt_en_i,
    input  logic               wdt_kick_i,
    output logic [NUM_OUT-1:0] rst_no,
    output logic [1:0]         rst_cause_o,
    output logic               busy_o
);
    localparam int MAX_SS = (STRETCH_CYCLES > STEP_CYCLES) ? STRETCH_CYCLES : STEP_CYCLES;
    localparam int MAXC   = (MAX_SS > WDT_TIMEOUT) ? MAX_SS : WDT_TIMEOUT;
    localparam int CW     = $clog2(MAXC + 1);
    localparam int IW     = (NUM_OUT > 1) ? $clog2(NUM_OUT) : 1;

    typedef enum logic [1:0] {ASSERT, RELEASE, RUN} state_t;

    state_t             state;
    logic [1:0]         ext_sync;
    logic [CW-1:0]      stretch_cnt;
    logic [CW-1:0]      step_cnt;
    logic [CW-1:0]      wdt_cnt;
    logic [IW-1:0]      idx;
    logic               ext_req;
    logic               wdt_exp;
    logic               trig;
    logic               step_done;
    logic               last_rel;
    logic [NUM_OUT-1:0] rel_set;

    always_ff @(posedge clk_i or negedge internal_rst_n) begin
        if (!internal_rst_n) ext_sync <= 2'b11;
        else                 ext_sync <= {ext_sync[0], ext_rst_ni};
    end

    assign ext_req   = !ext_sync[1];
    assign wdt_exp   = (state == RUN) && wdt_en_i && !wdt_kick_i &&
                       (wdt_cnt == CW'(WDT_TIMEOUT - 1));
    // Requests only start a new reset event once the stretch phase is over.
    assign trig      = (state != ASSERT) && (ext_req || wdt_exp || sw_rst_req_i);
    assign step_done = (state == RELEASE) && (step_cnt == CW'(STEP_CYCLES - 1));
    assign last_rel  = step_done && (idx == IW'(NUM_OUT - 1));

    always_ff @(posedge clk_i or negedge internal_rst_n) begin
        if (!internal_rst_n) begin
            state       <= ASSERT;
            stretch_cnt <= '0;
            step_cnt    <= '0;
            wdt_cnt     <= '0;
            idx         <= '0;
            rst_cause_o <= 2'd0;
            busy_o      <= 1'b1;
        end else if (trig) begin
            state       <= ASSERT;
            stretch_cnt <= '0;
            step_cnt    <= '0;
            wdt_cnt     <= '0;
            idx         <= '0;
            busy_o      <= 1'b1;
            rst_cause_o <= ext_req ? 2'd1 : (wdt_exp ? 2'd3 : 2'd2);
        end else begin
            case (state)
                ASSERT: begin
                    wdt_cnt <= '0;
                    if (ext_req) begin
                        stretch_cnt <= '0;
                    end else if (stretch_cnt == CW'(STRETCH_CYCLES - 1)) begin
                        state       <= RELEASE;
                        stretch_cnt <= '0;
                        step_cnt    <= '0;
                        idx         <= '0;
                    end else begin
                        stretch_cnt <= stretch_cnt + 1'b1;
                    end
                end
                RELEASE: begin
                    wdt_cnt <= '0;
                    if (step_done) begin
                        step_cnt <= '0;
                        if (last_rel) begin
                            state  <= RUN;
                            busy_o <= 1'b0;
                            idx    <= '0;
                        end else begin
                            idx <= idx + 1'b1;
                        end
                    end else begin
                        step_cnt <= step_cnt + 1'b1;
                    end
                end
                RUN: begin
                    if (!wdt_en_i || wdt_kick_i) wdt_cnt <= '0;
                    else                         wdt_cnt <= wdt_cnt + 1'b1;
                end
                default: begin
                    state  <= ASSERT;
                    busy_o <= 1'b1;
                end
            endcase
        end
    end

    // One flop per domain; a new reset event always overrides a pending release.
    for (genvar i = 0; i < NUM_OUT; i++) begin : g_lane
        assign rel_set[i] = step_done && (idx == IW'(i));
        reset_seq_lane u_lane (
            .clk_i          (clk_i),
            .internal_rst_n (internal_rst_n),
            .clr            (trig),
            .set            (rel_set[i]),
            .rst_no         (rst_no[i])
        );
    end
endmodule

// File: doc/reset_seq.md
Name: reset_seq

Overview:
Consumer-side reset controller that sits downstream of the power-on reset generator. It takes the board-level synchronized reset and merges it with external, software and watchdog reset requests. It stretches each reset event and then releases NUM_OUT reset domains one at a time in a fixed order. It also records the cause of the last reset for firmware.

Parameters:
NUM_OUT, 3, number of sequenced reset outputs (>=1); rst_no[0] is released first.
STRETCH_CYCLES, 8, cycles all outputs are held low after a reset source goes away (>=1).
STEP_CYCLES, 4, cycles between consecutive output releases (>=1).
WDT_TIMEOUT, 1024, watchdog expiry in cycles, counted in RUN without a kick (>=2).

Ports:
clk_i  input  1  system clock
internal_rst_n  input  1  asynchronous, active-low reset (power-on reset)
ext_rst_ni  input  1  asynchronous external reset button, active-low; synchronized internally
sw_rst_req_i  input  1  software reset request, sampled each cycle, active-high
wdt_en_i  input  1  watchdog enable
wdt_kick_i  input  1  watchdog kick, clears the watchdog counter
rst_no  output  NUM_OUT  sequenced active-low resets, registered
rst_cause_o  output  2  cause of last reset: 0 POR, 1 external, 2 software, 3 watchdog
busy_o  output  1  high while in ASSERT or RELEASE

Behaviour:
- Reset is decided: internal_rst_n is the reset (asynchronous, active-low); clk_i is the clock.
- Asynchronous reset (internal_rst_n low) drives: state=ASSERT, rst_no=all 0, rst_cause_o=0, busy_o=1, counters=0. The ext_rst_ni 2-flop synchronizer resets to 1 (not asserted).
- ext_rst_ni passes through a 2-flop synchronizer; ext_req = synchronized value low.
- States:
  - ASSERT: all rst_no=0. If ext_req is set, the stretch counter is held at 0. Otherwise it increments each cycle. At count STRETCH_CYCLES-1, go to RELEASE with idx=0 and the step counter at 0.
  - RELEASE: the step counter increments each cycle. At count STEP_CYCLES-1: set rst_no[idx]=1, idx++, and clear the step counter. When the last output is released, go to RUN.
  - RUN: all rst_no=1, busy_o=0.
- Timing from the first clock edge after internal_rst_n deasserts (edge 1): rst_no[i] rises at edge STRETCH_CYCLES+(i+1)*STEP_CYCLES. RUN is entered on the same edge as the last release. With defaults, rst_no rises at edges 12, 16, 20.
- Request handling in RELEASE or RUN:
  - sw_rst_req_i high at an edge: next state is ASSERT, rst_no becomes all 0 on that edge, and the stretch counter restarts at 0.
  - ext: rst_no goes low on the 3rd rising edge after ext_rst_ni falls (2 sync cycles plus 1).
- Request handling in ASSERT: sw and watchdog requests are ignored. ext_req holds the state in ASSERT (re-arms the stretch counter to 0).
- Simultaneous requests: priority ext > watchdog > sw. rst_cause_o is updated only on the transition into ASSERT from RELEASE or RUN, and is sticky otherwise.
- Watchdog:
  - The counter is active only in RUN with wdt_en_i=1. It is cleared when wdt_en_i=0, when wdt_kick_i=1, or outside RUN.
  - When the counter reaches WDT_TIMEOUT-1 with no kick that cycle, the block enters ASSERT with cause 3.
  - A kick in the terminal cycle wins (no reset).
  - Without kicks, expiry occurs on the WDT_TIMEOUT-th edge after RUN entry.
- Counter widths are sized to hold the maximum of STRETCH_CYCLES, STEP_CYCLES and WDT_TIMEOUT. No wrap-around is possible because every counter is compared for equality before overflow.
- rst_no bits are never released out of order. A lower index is always high whenever a higher index is high.

Test Plan:
- POR, defaults, no requests -> rst_no goes 000 until edge 12, then 001, 011 at 16, 111 at 20; busy_o falls at edge 20; rst_cause_o=0.
- In RUN, pulse sw_rst_req_i for 1 cycle at edge N -> rst_no=000 after edge N, release at N+12/16/20, rst_cause_o=2.
- In RUN, hold ext_rst_ni low for 10 cycles -> rst_no=000 after the 3rd edge; the stretch count restarts after the synchronized release; rst_cause_o=1. Repeat with ext falling mid-RELEASE -> outputs drop and the sequence restarts.
- WDT_TIMEOUT=16, wdt_en_i=1, no kicks -> reset at edge 16 after RUN entry, cause=3. Kick every 10 cycles -> no reset. Kick exactly on the terminal cycle -> no reset.
- sw_rst_req_i and an ext fall timed so both requests reach the FSM on the same edge -> cause=1. A sw request during ASSERT -> ignored; timing unchanged.
- Assert internal_rst_n mid-RELEASE -> rst_no=000 immediately (asynchronous) and cause=0; after release, the full sequence restarts from edge 1.
